instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the program counter and the fetch/execute datapath of the processor. It fetches each instruction from instruction memory with a request/acknowledge handshake and decodes its opcode class. It starts and waits for the execute unit, then issues exactly one program-counter update command per instruction: `next_instr`, `jump` or `cmp_jump`, with `jump_offset`. It sits between the instruction memory, the execute unit and the PC counter. It is the only driver of the PC counter's control inputs.

---
 rtl/seq_pkg.sv | 35 +++
 rtl/instr_class_decode.sv | 22 ++
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
// Holds the FSM state encoding, the opcode values and the opcode classes
// produced by instr_class_decode.
package seq_pkg;

  localparam int OPCODE_W = 4;

  // Opcode values found in ir[INSTR_W-1 -: OPCODE_W]
  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ALU   = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_CMPJ  = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // What the sequencer does with an instruction after DECODE
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,  // straight to UPDATE, PC += 1
    CLS_EXEC = 3'd1,  // ALU/LOAD/STORE: run the execute unit first
    CLS_JMP  = 3'd2,  // unconditional relative jump
    CLS_CMPJ = 3'd3,  // jump when cmp_flag is set
    CLS_HALT = 3'd4   // stop until reset
  } op_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational opcode-to-class mapping.
// Unknown opcodes fall into the NOP class so they simply advance the PC.
module instr_class_decode
  import seq_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  // Map each opcode onto the class that steers the sequencer
  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_ALU, OP_LOAD, OP_STORE: op_class = CLS_EXEC;
      OP_JMP:                    op_class = CLS_JMP;
      OP_CMPJ:                   op_class = CLS_CMPJ;
      OP_HALT:                   op_class = CLS_HALT;
      default:                   op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/update control FSM.
// Drives the PC counter with exactly one command per instruction in UPDATE.
// Optional feature macro SEQ_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
//
// Handshakes: imem_req stays high for the whole FETCH state and the fetch
// completes on the first cycle imem_ack is sampled high with imem_req high;
// exec_start is a single-cycle pulse in the first EXEC cycle and the unit
// reports completion by holding exec_done high in any EXEC cycle.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               cmp_flag,
  output logic               pc_enable,
  output logic               next_instr,
  output logic               jump,
  output logic               cmp_jump,
  output logic [ADDR_W-1:0]  jump_offset,
  output logic               busy,
  output logic               halted,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt,
`endif
  output logic [2:0]         fsm_state
);

  state_t    state;
  state_t    state_next;
  op_class_t op_class;

  instr_class_decode u_decode (
    .opcode   (ir[INSTR_W-1 -: OPCODE_W]),
    .op_class (op_class)
  );

  // State register; reset abandons any fetch or execute in flight
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (imem_ack) state_next = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_EXEC: state_next = S_EXEC;
          CLS_HALT: state_next = S_HALTED;
          default:  state_next = S_UPDATE;
        endcase
      end
      S_EXEC:   if (exec_done) state_next = S_UPDATE;
      S_UPDATE: state_next = S_FETCH;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  // Instruction register loads on the accepted fetch cycle
  always_ff @(posedge clk) begin
    if (reset)                            ir <= '0;
    else if (state == S_FETCH && imem_ack) ir <= imem_data;
  end

  // exec_start is registered so it is high only in the first EXEC cycle
  always_ff @(posedge clk) begin
    if (reset) exec_start <= 1'b0;
    else       exec_start <= (state == S_DECODE) && (state_next == S_EXEC);
  end

  // Outputs decoded from the state register (and ir/cmp_flag in UPDATE)
  always_comb begin
    imem_req   = (state == S_FETCH);
    pc_enable  = (state == S_UPDATE);
    jump       = (state == S_UPDATE) && (op_class == CLS_JMP);
    cmp_jump   = (state == S_UPDATE) && (op_class == CLS_CMPJ) && cmp_flag;
    next_instr = (state == S_UPDATE) && !(op_class == CLS_JMP) &&
                 !((op_class == CLS_CMPJ) && cmp_flag);
    busy       = (state != S_IDLE) && (state != S_HALTED);
    halted     = (state == S_HALTED);
  end

  assign jump_offset = ir[ADDR_W-1:0];
  assign fsm_state   = state;

`ifdef SEQ_PERF_CNT_EN
  // Busy-cycle and retired-instruction counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) cycle_cnt <= cycle_cnt + 32'd1;
      if ((state == S_UPDATE) || (state == S_DECODE && state_next == S_HALTED))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               imem_req;
  logic               imem_ack = 1'b0;
  logic [INSTR_W-1:0] imem_data = '0;
  logic [INSTR_W-1:0] ir;
  logic               exec_start;
  logic               exec_done = 1'b0;
  logic               cmp_flag = 1'b0;
  logic               pc_enable;
  logic               next_instr;
  logic               jump;
  logic               cmp_jump;
  logic [ADDR_W-1:0]  jump_offset;
  logic               busy;
  logic               halted;
  logic [2:0]         fsm_state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]        cycle_cnt;
  logic [31:0]        instr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .ir          (ir),
    .exec_start  (exec_start),
    .exec_done   (exec_done),
    .cmp_flag    (cmp_flag),
    .pc_enable   (pc_enable),
    .next_instr  (next_instr),
    .jump        (jump),
    .cmp_jump    (cmp_jump),
    .jump_offset (jump_offset),
    .busy        (busy),
    .halted      (halted),
`ifdef SEQ_PERF_CNT_EN
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt),
`endif
    .fsm_state   (fsm_state)
  );

  // Clock: 10 time-unit period
  always #5 clk = ~clk;

  // Advance to the next falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // Driver: complete a fetch from FETCH, ending at the DECODE negedge
  task automatic fetch(input logic [INSTR_W-1:0] instr);
    imem_data = instr;
    imem_ack  = 1'b1;
    step();
    imem_ack  = 1'b0;
  endtask

  // Bundle of all single-bit outputs: req,estart,pce,next,jump,cjump,busy,halted
  function automatic logic [7:0] outs();
    return {imem_req, exec_start, pc_enable, next_instr, jump, cmp_jump, busy, halted};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++; if (outs() !== 8'h00) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 8'h00); end
    total++; if (ir !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h exp=0000", ir); end
    total++; if (fsm_state !== 3'(S_IDLE)) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_nop();
    start = 1'b1; imem_data = 16'h0123; imem_ack = 1'b1;
    step();  // first FETCH cycle
    start = 1'b0;
    total++; if (outs() !== 8'b1000_0010) begin bad++; $display("FAIL nop_fetch got=%b exp=%b", outs(), 8'b1000_0010); end
    step();  // DECODE
    imem_ack = 1'b0;
    total++; if (ir !== 16'h0123) begin bad++; $display("FAIL nop_ir got=%h exp=0123", ir); end
    total++; if (outs() !== 8'b0000_0010) begin bad++; $display("FAIL nop_decode got=%b exp=%b", outs(), 8'b0000_0010); end
    step();  // UPDATE, third cycle after start
    total++; if (outs() !== 8'b0011_0010) begin bad++; $display("FAIL nop_update got=%b exp=%b", outs(), 8'b0011_0010); end
    total++; if (jump_offset !== 11'h123) begin bad++; $display("FAIL nop_offset got=%h exp=123", jump_offset); end
    step();  // back in FETCH
    total++; if (outs() !== 8'b1000_0010) begin bad++; $display("FAIL nop_refetch got=%b exp=%b", outs(), 8'b1000_0010); end
`ifdef SEQ_PERF_CNT_EN
    total++; if (instr_cnt !== 32'd1) begin bad++; $display("FAIL nop_instr_cnt got=%0d exp=1", instr_cnt); end
`endif
  endtask

  task automatic test_alu();
    int pulses = 0;
    fetch(16'h1000);
    step();  // first EXEC cycle
    for (int i = 1; i <= 5; i++) begin
      if (exec_start === 1'b1) pulses++;
      total++; if (fsm_state !== 3'(S_EXEC) || pc_enable !== 1'b0) begin
        bad++; $display("FAIL alu_exec_wait cyc=%0d state=%0d pce=%b exp_state=%0d pce=0", i, fsm_state, pc_enable, S_EXEC);
      end
      if (i == 5) exec_done = 1'b1;
      step();
    end
    exec_done = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL alu_exec_start_pulses got=%0d exp=1", pulses); end
    total++; if (outs() !== 8'b0011_0010) begin bad++; $display("FAIL alu_update got=%b exp=%b", outs(), 8'b0011_0010); end
    step();
  endtask

  task automatic test_jmp();
    fetch(16'h47FE);
    step();  // UPDATE
    total++; if (outs() !== 8'b0010_1010) begin bad++; $display("FAIL jmp_update got=%b exp=%b", outs(), 8'b0010_1010); end
    total++; if (jump_offset !== 11'h7FE) begin bad++; $display("FAIL jmp_offset got=%h exp=7fe", jump_offset); end
    step();
  endtask

  task automatic test_cmpj();
    fetch(16'h5005);
    cmp_flag = 1'b1;
    step();
    total++; if (outs() !== 8'b0010_0110) begin bad++; $display("FAIL cmpj_taken got=%b exp=%b", outs(), 8'b0010_0110); end
    total++; if (jump_offset !== 11'h005) begin bad++; $display("FAIL cmpj_offset got=%h exp=005", jump_offset); end
    step();
    fetch(16'h5000);
    cmp_flag = 1'b0;
    step();
    total++; if (outs() !== 8'b0011_0010) begin bad++; $display("FAIL cmpj_not_taken got=%b exp=%b", outs(), 8'b0011_0010); end
    step();
  endtask

  task automatic test_unknown_op();
    fetch(16'h7ABC);
    step();  // unknown opcode behaves as NOP: straight to UPDATE
    total++; if (outs() !== 8'b0011_0010) begin bad++; $display("FAIL unknown_op_update got=%b exp=%b", outs(), 8'b0011_0010); end
    step();
  endtask

  task automatic test_ack_wait();
    int held = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req === 1'b1 && ir === 16'h7ABC) held++;
      step();
    end
    total++; if (held !== 5) begin bad++; $display("FAIL ack_wait_hold got=%0d exp=5", held); end
    fetch(16'h3456);
    total++; if (ir !== 16'h3456) begin bad++; $display("FAIL ack_wait_ir got=%h exp=3456", ir); end
    step();  // first EXEC cycle of STORE
    total++; if (exec_start !== 1'b1) begin bad++; $display("FAIL store_exec_start got=%b exp=1", exec_start); end
  endtask

  task automatic test_reset_mid_exec_halt();
    exec_done = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;  // exec_done still high: must be ignored in IDLE
    total++; if (outs() !== 8'h00 || ir !== 16'h0000) begin bad++; $display("FAIL mid_exec_reset outs=%b ir=%h exp=00000000 0000", outs(), ir); end
    step();
    exec_done = 1'b0;
    total++; if (fsm_state !== 3'(S_IDLE)) begin bad++; $display("FAIL mid_exec_stay_idle got=%0d exp=%0d", fsm_state, S_IDLE); end
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(16'hF000);
    step();  // HALTED
    total++; if (outs() !== 8'b0000_0001) begin bad++; $display("FAIL halt_outs got=%b exp=%b", outs(), 8'b0000_0001); end
`ifdef SEQ_PERF_CNT_EN
    total++; if (instr_cnt !== 32'd1) begin bad++; $display("FAIL halt_instr_cnt got=%0d exp=1", instr_cnt); end
    total++; if (cycle_cnt !== 32'd2) begin bad++; $display("FAIL halt_cycle_cnt got=%0d exp=2", cycle_cnt); end
`endif
    start = 1'b1; imem_ack = 1'b1;
    step(); step(); step();
    start = 1'b0; imem_ack = 1'b0;
    total++; if (outs() !== 8'b0000_0001) begin bad++; $display("FAIL halt_ignores_start got=%b exp=%b", outs(), 8'b0000_0001); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (outs() !== 8'h00 || fsm_state !== 3'(S_IDLE)) begin bad++; $display("FAIL halt_reset outs=%b state=%0d exp=00000000 %0d", outs(), fsm_state, S_IDLE); end
  endtask

  initial begin
    step();
    test_reset();
    test_nop();
    test_alu();
    test_jmp();
    test_cmpj();
    test_unknown_op();
    test_ack_wait();
    test_reset_mid_exec_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
